// File: rtl/pb_scan_debouncer.sv
// Multi-button push-button debouncer. A round-robin scheduler time-shares one
// compare/increment engine across N_PB buttons, each with its own count register.
module pb_scan_debouncer #(
  parameter int N_PB       = 4,
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 16,
  parameter int CNT_W      = 5,
  localparam int IDX_W     = (N_PB > 1) ? $clog2(N_PB) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_PB-1:0]  PB,
  input  logic [N_PB-1:0]  pb_en,
  output logic [N_PB-1:0]  PB_state,
  output logic [N_PB-1:0]  PB_down,
  output logic [N_PB-1:0]  PB_up,
  output logic [IDX_W-1:0] scan_idx
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_DISABLE,
    EV_STABLE,
    EV_ACCEPT,
    EV_COUNT
  } ev_t;

  logic [N_PB-1:0]  sync1;
  logic [N_PB-1:0]  sync2;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [CNT_W-1:0] cnt [N_PB];

  ev_t              ev;
  logic             sel_pressed;
  logic             sel_state;
  logic             sel_en;
  logic [CNT_W-1:0] sel_cnt;

  // NOTE: non-blocking assignments let sync2 capture the old sync1, forming two real stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= PB;
      sync2 <= sync1;
    end
  end

  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick)
        scan_idx <= (scan_idx == IDX_W'(N_PB - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  // Shared engine: classify the owning button's slot outcome.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_pressed = ~sync2[scan_idx];
    sel_state   = PB_state[scan_idx];
    sel_en      = pb_en[scan_idx];
    sel_cnt     = cnt[scan_idx];
    ev          = EV_NONE;
    if (tick) begin
      if (!sel_en)
        ev = EV_DISABLE;
      else if (sel_pressed == sel_state)
        ev = EV_STABLE;
      else if (sel_cnt == CNT_W'(STABLE_CNT - 1))
        ev = EV_ACCEPT;
      else
        ev = EV_COUNT;
    end
  end

  // NOTE: the count array is reset explicitly because a reset must discard any partial debounce.
  always_ff @(posedge clk) begin
    if (rst) begin
      PB_state <= '0;
      PB_down  <= '0;
      PB_up    <= '0;
      for (int i = 0; i < N_PB; i++)
        cnt[i] <= '0;
    end else begin
      PB_down <= '0;
      PB_up   <= '0;
      case (ev)
        EV_DISABLE: begin
          PB_state[scan_idx] <= 1'b0;
          cnt[scan_idx]      <= '0;
        end
        EV_STABLE: cnt[scan_idx] <= '0;
        EV_ACCEPT: begin
          PB_state[scan_idx] <= sel_pressed;
          cnt[scan_idx]      <= '0;
          PB_down[scan_idx]  <= sel_pressed;
          PB_up[scan_idx]    <= ~sel_pressed;
        end
        EV_COUNT:  cnt[scan_idx] <= sel_cnt + 1'b1;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_pb_scan_debouncer.sv
// Directed bench for pb_scan_debouncer: N_PB=4, TICK_DIV=4, STABLE_CNT=3.
// Expected pulse cycles come from the slot timing derived from the reset release.
module tb_pb_scan_debouncer;

  localparam int N_PB       = 4;
  localparam int TICK_DIV   = 4;
  localparam int STABLE_CNT = 3;
  localparam int CNT_W      = 5;
  localparam int PERIOD     = N_PB * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] PB = 4'hF;
  logic [3:0] pb_en = 4'hF;
  logic [3:0] PB_state;
  logic [3:0] PB_down;
  logic [3:0] PB_up;
  logic [1:0] scan_idx;

  pb_scan_debouncer #(
    .N_PB(N_PB), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .PB(PB), .pb_en(pb_en),
    .PB_state(PB_state), .PB_down(PB_down), .PB_up(PB_up), .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int down_cnt [4] = '{default: 0};
  int up_cnt   [4] = '{default: 0};
  int down_cyc [4] = '{default: 0};
  int up_cyc   [4] = '{default: 0};
  int multi = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (PB_down[i]) begin
        down_cnt[i] <= down_cnt[i] + 1;
        down_cyc[i] <= cyc;
      end
      if (PB_up[i]) begin
        up_cnt[i] <= up_cnt[i] + 1;
        up_cyc[i] <= cyc;
      end
    end
    if ($countones(PB_down | PB_up) > 1) multi <= multi + 1;
  end

  int errors = 0;
  int checks = 0;
  int r0 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // First tick edge of button b at or after edge e; button b owns edges r0+TICK_DIV*(b+1)+PERIOD*m.
  function automatic int slot_after(input int b, input int e);
    int t;
    t = e;
    for (int k = 0; k < 2 * PERIOD; k++)
      if (((t - r0 - TICK_DIV * (b + 1)) % PERIOD) != 0) t++;
    return t;
  endfunction

  function automatic int pulses_total();
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += down_cnt[i] + up_cnt[i];
    return s;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, lat, d0, u0, d1, d3, u3, tot, drop, ce;
    bit found;

    // Reset state and scheduler cadence
    step(3);
    check("rst_state", PB_state, 0);
    check("rst_down", PB_down, 0);
    check("rst_up", PB_up, 0);
    check("rst_scan", scan_idx, 0);
    rst = 1'b0;
    r0 = cyc;
    for (int j = 1; j <= 20; j++) begin
      step(1);
      check($sformatf("scan_seq_%0d", j), scan_idx, (j / 4) % 4);
    end
    step(180);
    check("idle_state", PB_state, 0);
    check("idle_pulses", pulses_total(), 0);

    // Clean press and release of button 0
    d0 = down_cnt[0]; u0 = up_cnt[0];
    PB[0] = 1'b0; c0 = cyc;
    step(300);
    lat = down_cyc[0] - c0;
    check("p0_down_count", down_cnt[0] - d0, 1);
    check("p0_down_cyc", down_cyc[0], slot_after(0, c0 + 3) + PERIOD * (STABLE_CNT - 1));
    check("p0_down_window", (lat >= 35 && lat <= 51), 1);
    check("p0_state", PB_state[0], 1);
    check("p0_no_up", up_cnt[0] - u0, 0);
    PB[0] = 1'b1; c0 = cyc;
    step(300);
    lat = up_cyc[0] - c0;
    check("r0_up_count", up_cnt[0] - u0, 1);
    check("r0_up_cyc", up_cyc[0], slot_after(0, c0 + 3) + PERIOD * (STABLE_CNT - 1));
    check("r0_up_window", (lat >= 35 && lat <= 51), 1);
    check("r0_state", PB_state[0], 0);

    // Bounce on button 2 must be rejected
    tot = pulses_total();
    PB[2] = 1'b0; step(5);
    PB[2] = 1'b1; step(6);
    PB[2] = 1'b0; step(9);
    PB[2] = 1'b1; step(6);
    PB[2] = 1'b0; step(7);
    PB[2] = 1'b1; step(60);
    check("bounce_pulses", pulses_total() - tot, 0);
    check("bounce_state", PB_state[2], 0);
    check("bounce_cnt", dut.cnt[2], 0);

    // Simultaneous press on buttons 1 and 3: pulses one slot group apart
    d1 = down_cnt[1]; d3 = down_cnt[3]; u3 = up_cnt[3];
    PB[1] = 1'b0; PB[3] = 1'b0; c0 = cyc;
    step(80);
    check("sim_b1_count", down_cnt[1] - d1, 1);
    check("sim_b3_count", down_cnt[3] - d3, 1);
    check("sim_b1_cyc", down_cyc[1], slot_after(1, c0 + 3) + PERIOD * (STABLE_CNT - 1));
    check("sim_b3_cyc", down_cyc[3], slot_after(3, c0 + 3) + PERIOD * (STABLE_CNT - 1));
    check("sim_spacing", (down_cyc[3] > down_cyc[1]) ? down_cyc[3] - down_cyc[1]
                                                      : down_cyc[1] - down_cyc[3], 8);
    check("sim_no_overlap", multi, 0);
    PB[3] = 1'b1;
    step(80);
    check("b3_release", up_cnt[3] - u3, 1);
    check("b1_held_state", PB_state, 4'b0010);

    // Disable an accepted button, then re-enable while still held
    d0 = down_cnt[0]; u0 = up_cnt[0];
    PB[0] = 1'b0;
    step(70);
    check("en_pressed", PB_state[0], 1);
    check("en_down", down_cnt[0] - d0, 1);
    pb_en[0] = 1'b0; ce = cyc;
    found = 1'b0; drop = 0;
    for (int i = 0; i < 24 && !found; i++) begin
      step(1);
      if (PB_state[0] == 1'b0) begin
        found = 1'b1;
        drop = cyc;
      end
    end
    check("dis_seen", found, 1);
    check("dis_cyc", drop, slot_after(0, ce + 1));
    step(40);
    check("dis_no_up", up_cnt[0] - u0, 0);
    check("dis_state", PB_state[0], 0);
    d0 = down_cnt[0];
    pb_en[0] = 1'b1; ce = cyc;
    step(70);
    check("reen_down", down_cnt[0] - d0, 1);
    check("reen_cyc", down_cyc[0], slot_after(0, ce + 1) + PERIOD * (STABLE_CNT - 1));
    PB[0] = 1'b1;
    step(70);

    // Reset mid-count on button 3 while button 1 is still accepted
    PB[3] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1);
      if (dut.cnt[3] == 2) found = 1'b1;
    end
    check("mid_cnt_reached", found, 1);
    tot = pulses_total();
    d1 = down_cnt[1]; d3 = down_cnt[3];
    rst = 1'b1;
    step(1);
    r0 = cyc;
    rst = 1'b0;
    check("mrst_state", PB_state, 0);
    check("mrst_scan", scan_idx, 0);
    check("mrst_cnt", dut.cnt[3], 0);
    check("mrst_pulse", PB_down | PB_up, 0);
    step(29);
    check("mrst_quiet", pulses_total() - tot, 0);
    check("mrst_state_hold", PB_state, 0);
    step(30);
    check("mrst_b1_count", down_cnt[1] - d1, 1);
    check("mrst_b1_cyc", down_cyc[1], r0 + 40);
    check("mrst_b3_count", down_cnt[3] - d3, 1);
    check("mrst_b3_cyc", down_cyc[3], r0 + 48);
    check("final_no_overlap", multi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
